// File: rtl/cache_axi_arbiter.sv
// Round-robin arbiter that funnels NUM_CH cache requesters onto a single AXI bridge,
// with an optional writeback-then-refill sequence and a one-hot done pulse per channel.
module cache_axi_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int STRB_W  = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [3*NUM_CH-1:0]         req_op,
  input  logic [ADDR_W*NUM_CH-1:0]    req_ad,
  input  logic [ADDR_W*NUM_CH-1:0]    req_wb_ad,
  input  logic [DATA_W*NUM_CH-1:0]    req_wword,
  input  logic [BLOCK_W*NUM_CH-1:0]   req_wblock,
  input  logic [STRB_W*NUM_CH-1:0]    req_wstrb,
  input  logic [NUM_CH-1:0]           req_cached,
  output logic [NUM_CH-1:0]           done,
  output logic [DATA_W-1:0]           rword,
  output logic [BLOCK_W-1:0]          rblock,
  output logic [2:0]                  axi_req,
  output logic [ADDR_W-1:0]           axi_ad,
  output logic [DATA_W-1:0]           axi_wword,
  output logic [BLOCK_W-1:0]          axi_wblock,
  output logic [STRB_W-1:0]           axi_wstrb,
  output logic                        axi_cached,
  input  logic                        axi_ready,
  input  logic                        axi_finish,
  input  logic [DATA_W-1:0]           axi_rword,
  input  logic [BLOCK_W-1:0]          axi_rblock
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_LB   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_SB   = 3'd4;
  localparam logic [2:0] OP_WBR  = 3'd5;

  localparam logic [2:0] AX_NONE = 3'd0;
  localparam logic [2:0] AX_LW   = 3'd1;
  localparam logic [2:0] AX_LB   = 3'd2;
  localparam logic [2:0] AX_WW   = 3'd3;
  localparam logic [2:0] AX_WB   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_FIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     r_grant;
  logic [NUM_CH-1:0]   r_mask;
  logic                r_wb_phase;
  logic [ADDR_W-1:0]   r_refill_ad;

  logic                w_found;
  logic [CH_W-1:0]     w_sel;
  int                  w_idx;
  logic [2:0]          w_cand_op;
  logic [2:0]          w_sel_op;
  logic [ADDR_W-1:0]   w_sel_ad;
  logic [ADDR_W-1:0]   w_sel_wb_ad;
  logic [DATA_W-1:0]   w_sel_wword;
  logic [BLOCK_W-1:0]  w_sel_wblock;
  logic [STRB_W-1:0]   w_sel_wstrb;
  logic                w_sel_cached;
  logic [CH_W-1:0]     w_next_ptr;

  // First bridge command for a requester op; WB_REFILL starts with its writeback.
  function automatic logic [2:0] axi_code(input logic [2:0] op);
    case (op)
      OP_LW:         axi_code = AX_LW;
      OP_LB:         axi_code = AX_LB;
      OP_SW:         axi_code = AX_WW;
      OP_SB, OP_WBR: axi_code = AX_WB;
      default:       axi_code = AX_NONE;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin search from the pointer, skipping the channel served just before.
  always_comb begin
    w_found      = 1'b0;
    w_sel        = '0;
    w_idx        = 0;
    w_cand_op    = OP_NONE;
    w_sel_op     = OP_NONE;
    w_sel_ad     = '0;
    w_sel_wb_ad  = '0;
    w_sel_wword  = '0;
    w_sel_wblock = '0;
    w_sel_wstrb  = '0;
    w_sel_cached = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      w_cand_op = req_op[w_idx*3 +: 3];
      if (!w_found && (w_cand_op != OP_NONE) && (w_cand_op <= OP_WBR) && !r_mask[w_idx]) begin
        w_found      = 1'b1;
        w_sel        = CH_W'(w_idx);
        w_sel_op     = w_cand_op;
        w_sel_ad     = req_ad[w_idx*ADDR_W +: ADDR_W];
        w_sel_wb_ad  = req_wb_ad[w_idx*ADDR_W +: ADDR_W];
        w_sel_wword  = req_wword[w_idx*DATA_W +: DATA_W];
        w_sel_wblock = req_wblock[w_idx*BLOCK_W +: BLOCK_W];
        w_sel_wstrb  = req_wstrb[w_idx*STRB_W +: STRB_W];
        w_sel_cached = req_cached[w_idx];
      end
    end
  end

  assign w_next_ptr = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_mask      <= '0;
      r_wb_phase  <= 1'b0;
      r_refill_ad <= '0;
      done        <= '0;
      rword       <= '0;
      rblock      <= '0;
      axi_req     <= AX_NONE;
      axi_ad      <= '0;
      axi_wword   <= '0;
      axi_wblock  <= '0;
      axi_wstrb   <= '0;
      axi_cached  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mask <= '0;
          if (w_found) begin
            r_grant     <= w_sel;
            r_wb_phase  <= (w_sel_op == OP_WBR);
            r_refill_ad <= w_sel_ad;
            axi_req     <= axi_code(w_sel_op);
            axi_ad      <= (w_sel_op == OP_WBR) ? w_sel_wb_ad : w_sel_ad;
            axi_wword   <= (w_sel_op == OP_SW) ? w_sel_wword : '0;
            axi_wstrb   <= (w_sel_op == OP_SW) ? w_sel_wstrb : '0;
            axi_wblock  <= ((w_sel_op == OP_SB) || (w_sel_op == OP_WBR)) ? w_sel_wblock : '0;
            axi_cached  <= w_sel_cached;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (axi_ready) begin
            axi_req <= AX_NONE;
            r_state <= S_WAIT_FIN;
          end
        end
        S_WAIT_FIN: begin
          if (axi_finish) begin
            if (r_wb_phase) begin
              // Writeback complete: reissue as a block refill at the original address.
              r_wb_phase <= 1'b0;
              axi_ad     <= r_refill_ad;
              axi_req    <= AX_LB;
              r_state    <= S_ISSUE;
            end else begin
              rword   <= axi_rword;
              rblock  <= axi_rblock;
              done    <= onehot(r_grant);
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done    <= '0;
          r_ptr   <= w_next_ptr;
          r_mask  <= onehot(r_grant);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
